bp_update_ctrl: RTL and testbench

Sequences all writes into the GShare predictor tables (BTB, PHT) through one shared write port. Runs a one-entry-per-cycle clearing sweep after reset and on a flush command. Buffers resolved-branch updates from EX in a small FIFO and issues them one per cycle. Owns the global history register and the branch/mispredict statistics counters.

---
 rtl/bp_update_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_bp_update_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: sole writer of the GShare BTB/PHT tables. Sweeps all entries clear after
// reset and on flush, queues resolved-branch updates from EX in a small FIFO and drains them
// one per cycle. Also owns the global history register and the branch statistics counters.
module bp_update_ctrl #(
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TAG_BITS   = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_pc,
    input  logic                  ex_taken,
    input  logic [31:0]           ex_target,
    input  logic                  ex_mispredict,
    input  logic                  flush_req,
    output logic                  ex_stall,
    output logic                  upd_valid,
    output logic                  upd_clear,
    output logic [INDEX_BITS-1:0] upd_index,
    output logic [INDEX_BITS-1:0] upd_pht_index,
    output logic [TAG_BITS-1:0]   upd_tag,
    output logic [31:0]           upd_target,
    output logic                  upd_taken,
    output logic [INDEX_BITS-1:0] ghr,
    output logic                  pred_enable,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef enum logic [1:0] {StInit, StRun, StFlush} state_e;

    typedef struct packed {
        logic [INDEX_BITS-1:0] index;
        logic [INDEX_BITS-1:0] pht_index;
        logic [TAG_BITS-1:0]   tag;
        logic [31:0]           target;
        logic                  taken;
    } entry_t;

    state_e                state_q;
    logic [INDEX_BITS-1:0] sweep_ptr_q;
    logic                  pred_enable_q;
    logic                  upd_valid_q;
    logic                  upd_clear_q;
    logic [INDEX_BITS-1:0] upd_index_q;
    logic [INDEX_BITS-1:0] upd_pht_index_q;
    logic [TAG_BITS-1:0]   upd_tag_q;
    logic [31:0]           upd_target_q;
    logic                  upd_taken_q;

    entry_t                mem_q [DEPTH];
    // Extra MSB on each pointer separates full from empty when the low bits match.
    logic [PtrW:0]         wr_ptr_q;
    logic [PtrW:0]         rd_ptr_q;
    logic [INDEX_BITS-1:0] ghr_q;
    logic [31:0]           branch_count_q;
    logic [31:0]           mispredict_count_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  flush_go;
    logic                  push;
    logic                  pop;
    logic [INDEX_BITS-1:0] pc_index;
    entry_t                push_entry;
    entry_t                head;

    // Push/pop qualification; a flush edge swallows any concurrent EX update without stalling.
    always_comb begin
        fifo_empty           = (wr_ptr_q == rd_ptr_q);
        fifo_full            = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                               (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        flush_go             = (state_q == StRun) && flush_req;
        push                 = ex_valid && !fifo_full && !flush_go;
        pop                  = (state_q == StRun) && !flush_req && !fifo_empty;
        ex_stall             = ex_valid && fifo_full && !flush_go;
        pc_index             = ex_pc[INDEX_BITS+1:2];
        push_entry.index     = pc_index;
        push_entry.pht_index = ghr_q ^ pc_index;
        push_entry.tag       = ex_pc[31:INDEX_BITS+2];
        push_entry.target    = ex_target;
        push_entry.taken     = ex_taken;
        head                 = mem_q[rd_ptr_q[PtrW-1:0]];
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= push_entry;
        end
    end

    // FIFO pointers, global history and saturating statistics counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            ghr_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (flush_go) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ghr_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                ghr_q    <= {ghr_q[INDEX_BITS-2:0], ex_taken};
                if (branch_count_q != '1) begin
                    branch_count_q <= branch_count_q + 32'd1;
                end
                if (ex_mispredict && (mispredict_count_q != '1)) begin
                    mispredict_count_q <= mispredict_count_q + 32'd1;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Control FSM with registered write-port outputs: sweep clears, then drain the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StInit;
            sweep_ptr_q     <= '0;
            pred_enable_q   <= 1'b0;
            upd_valid_q     <= 1'b0;
            upd_clear_q     <= 1'b0;
            upd_index_q     <= '0;
            upd_pht_index_q <= '0;
            upd_tag_q       <= '0;
            upd_target_q    <= '0;
            upd_taken_q     <= 1'b0;
        end else begin
            upd_valid_q     <= 1'b0;
            upd_clear_q     <= 1'b0;
            upd_index_q     <= '0;
            upd_pht_index_q <= '0;
            upd_tag_q       <= '0;
            upd_target_q    <= '0;
            upd_taken_q     <= 1'b0;
            case (state_q)
                StInit, StFlush: begin
                    upd_valid_q     <= 1'b1;
                    upd_clear_q     <= 1'b1;
                    upd_index_q     <= sweep_ptr_q;
                    upd_pht_index_q <= sweep_ptr_q;
                    sweep_ptr_q     <= sweep_ptr_q + 1'b1;
                    if (sweep_ptr_q == '1) begin
                        state_q       <= StRun;
                        pred_enable_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (flush_req) begin
                        state_q       <= StFlush;
                        sweep_ptr_q   <= '0;
                        pred_enable_q <= 1'b0;
                    end else if (!fifo_empty) begin
                        upd_valid_q     <= 1'b1;
                        upd_index_q     <= head.index;
                        upd_pht_index_q <= head.pht_index;
                        upd_tag_q       <= head.tag;
                        upd_target_q    <= head.target;
                        upd_taken_q     <= head.taken;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign upd_valid        = upd_valid_q;
    assign upd_clear        = upd_clear_q;
    assign upd_index        = upd_index_q;
    assign upd_pht_index    = upd_pht_index_q;
    assign upd_tag          = upd_tag_q;
    assign upd_target       = upd_target_q;
    assign upd_taken        = upd_taken_q;
    assign ghr              = ghr_q;
    assign pred_enable      = pred_enable_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Randomized bench for bp_update_ctrl against a queue-based reference model.
module tb_bp_update_ctrl;

    localparam int IB = 5;
    localparam int DP = 4;
    localparam int TB = 25;
    localparam int NENT = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ex_valid, ex_taken, ex_mispredict, flush_req;
    logic [31:0]   ex_pc, ex_target;
    logic          ex_stall, upd_valid, upd_clear, upd_taken, pred_enable;
    logic [IB-1:0] upd_index, upd_pht_index, ghr;
    logic [TB-1:0] upd_tag;
    logic [31:0]   upd_target, branch_count, mispredict_count;

    bp_update_ctrl #(.INDEX_BITS(IB), .DEPTH(DP), .TAG_BITS(TB)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_mispredict    (ex_mispredict),
        .flush_req        (flush_req),
        .ex_stall         (ex_stall),
        .upd_valid        (upd_valid),
        .upd_clear        (upd_clear),
        .upd_index        (upd_index),
        .upd_pht_index    (upd_pht_index),
        .upd_tag          (upd_tag),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .ghr              (ghr),
        .pred_enable      (pred_enable),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of pending updates plus plain counters.
    typedef struct {
        int unsigned idx;
        int unsigned pht;
        int unsigned tag;
        logic [31:0] tgt;
        bit          tk;
    } ent_t;

    ent_t            m_q[$];
    bit              m_run, m_pe;
    int unsigned     m_idx, m_ghr;
    longint unsigned m_bc, m_mc;
    bit              e_uv, e_uc, e_tk;
    int unsigned     e_ui, e_upi, e_ut;
    logic [31:0]     e_tgt;

    function automatic void model_reset();
        m_q.delete();
        m_run = 0; m_pe = 0; m_idx = 0; m_ghr = 0; m_bc = 0; m_mc = 0;
        e_uv = 0; e_uc = 0; e_tk = 0; e_ui = 0; e_upi = 0; e_ut = 0; e_tgt = '0;
    endfunction

    function automatic logic [127:0] dut_upd();
        return {upd_clear, upd_index, upd_pht_index, upd_tag, upd_target, upd_taken};
    endfunction

    task automatic check_outs();
        logic [127:0] exp_upd;
        exp_upd = {e_uc, IB'(e_ui), IB'(e_upi), TB'(e_ut), e_tgt, e_tk};
        check_eq("upd_valid", upd_valid, e_uv);
        if (e_uv) check_eq("upd_fields", dut_upd(), exp_upd);
        check_eq("ghr", ghr, IB'(m_ghr));
        check_eq("pred_enable", pred_enable, m_pe);
        check_eq("branch_count", branch_count, m_bc);
        check_eq("mispredict_count", mispredict_count, m_mc);
    endtask

    // One clock: check the combinational stall, take the edge, advance the model, compare.
    task automatic step();
        bit   fl, full;
        ent_t e, n;
        int unsigned pcidx;
        @(negedge clk);
        fl   = m_run && flush_req;
        full = (m_q.size() == DP);
        check_eq("ex_stall", ex_stall, ex_valid && full && !fl);
        @(posedge clk);
        e_uv = 0; e_uc = 0; e_tk = 0; e_ui = 0; e_upi = 0; e_ut = 0; e_tgt = '0;
        if (fl) begin
            m_q.delete();
            m_ghr = 0; m_run = 0; m_idx = 0; m_pe = 0;
        end else begin
            if (!m_run) begin
                e_uv = 1; e_uc = 1; e_ui = m_idx; e_upi = m_idx;
                m_idx++;
                if (m_idx == NENT) begin m_run = 1; m_pe = 1; end
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                e_uv = 1; e_ui = e.idx; e_upi = e.pht; e_ut = e.tag; e_tgt = e.tgt; e_tk = e.tk;
            end
            if (ex_valid && !full) begin
                pcidx = (ex_pc / 4) % NENT;
                n.idx = pcidx;
                n.pht = m_ghr ^ pcidx;
                n.tag = ex_pc / 128;
                n.tgt = ex_target;
                n.tk  = ex_taken;
                m_q.push_back(n);
                m_ghr = (m_ghr * 2 + (ex_taken ? 1 : 0)) % NENT;
                if (m_bc < 64'hFFFF_FFFF) m_bc++;
                if (ex_mispredict && m_mc < 64'hFFFF_FFFF) m_mc++;
            end
        end
        #1;
        check_outs();
    endtask

    task automatic idle();
        ex_valid = 0; ex_pc = '0; ex_taken = 0; ex_target = '0; ex_mispredict = 0; flush_req = 0;
    endtask

    task automatic drive_rand(input int p_valid, input int p_flush);
        ex_valid      = ($urandom_range(99) < p_valid);
        ex_pc         = $urandom;
        ex_taken      = $urandom_range(1);
        ex_target     = $urandom;
        ex_mispredict = $urandom_range(1);
        flush_req     = ($urandom_range(99) < p_flush);
    endtask

    // Asynchronous reset pulse between clock edges; called just after a rising edge.
    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1 model_reset();
        check_outs();
        check_eq("rst_upd_zero", dut_upd(), '0);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 model_reset();
        check_outs();
        check_eq("rst_upd_zero", dut_upd(), '0);
        #1 reset = 1'b0;

        // Full sweep then the first RUN cycle.
        repeat (NENT + 1) step();

        // Single directed update right after the sweep.
        ex_valid = 1; ex_pc = 32'h0000_0088; ex_taken = 1; ex_target = 32'h40;
        step();
        idle();
        step();
        check_eq("tp_index", upd_index, 2);
        check_eq("tp_pht_index", upd_pht_index, 2);
        check_eq("tp_tag", upd_tag, 1);
        check_eq("tp_target", upd_target, 32'h40);
        check_eq("tp_taken", upd_taken, 1);
        check_eq("tp_ghr", ghr, 1);
        check_eq("tp_bcount", branch_count, 1);

        // Randomized traffic with occasional flushes.
        repeat (300) begin
            drive_rand(60, 3);
            step();
        end
        idle();
        repeat (40) step();

        // Reset mid-sweep at index 10, then restart from index 0.
        pulse_reset();
        repeat (11) step();
        check_eq("sweep_idx10", upd_index, 10);
        pulse_reset();
        check_eq("rst_mid_valid", upd_valid, 0);
        step();
        check_eq("restart_idx0", {upd_valid, upd_clear, upd_index}, {2'b11, 5'd0});
        repeat (NENT) step();

        // Five pushes during INIT: fifth stalls, four drain in order after the sweep.
        pulse_reset();
        repeat (5) begin
            drive_rand(100, 0);
            step();
        end
        idle();
        check_eq("burst_bcount", branch_count, 4);
        repeat (NENT + 8) step();

        // Three queued entries, then flush with a concurrent EX update.
        pulse_reset();
        repeat (5) begin
            drive_rand(100, 0);
            step();
        end
        idle();
        repeat (NENT - 5 + 1) step();
        drive_rand(100, 0);
        flush_req = 1;
        step();
        idle();
        check_eq("flush_bcount", branch_count, 4);
        check_eq("flush_ghr", ghr, 0);
        repeat (NENT + 2) step();

        // Counter saturation.
        force dut.branch_count_q = 32'hFFFF_FFFE;
        force dut.mispredict_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.branch_count_q;
        release dut.mispredict_count_q;
        m_bc = 64'hFFFF_FFFE;
        m_mc = 64'hFFFF_FFFE;
        repeat (3) begin
            drive_rand(100, 0);
            ex_mispredict = 1;
            step();
        end
        idle();
        step();
        check_eq("sat_mcount", mispredict_count, 32'hFFFF_FFFF);
        check_eq("sat_bcount", branch_count, 32'hFFFF_FFFF);

        // More random traffic on top of saturated counters.
        repeat (60) begin
            drive_rand(70, 2);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
